// File: rtl/nco_seq_ctrl_if.sv
// nco_seq_ctrl_if: config/control and status bundle between UI logic and the NCO sequencer
interface nco_seq_ctrl_if #(
    parameter int ACC_W   = 32,
    parameter int ADDR_W  = 5,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic [3:0]         wave_sel;
    logic [ACC_W-1:0]   tuning_word;
    logic [DWELL_W-1:0] dwell_cycles;
    logic               auto_cycle;
    logic [3:0]         signal_out;
    logic [2:0]         state_out;
    logic [ADDR_W-1:0]  lut_addr;
    logic               sample_en;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, stop, wave_sel, tuning_word, dwell_cycles, auto_cycle,
        input  signal_out, state_out, lut_addr, sample_en, busy, done, err
    );

    modport slave (
        input  start, stop, wave_sel, tuning_word, dwell_cycles, auto_cycle,
        output signal_out, state_out, lut_addr, sample_en, busy, done, err
    );
endinterface

// File: rtl/nco_seq_ctrl.sv
// nco_seq_ctrl: sequencer for the LUT wave generator; latches config, runs the phase
// accumulator, counts periods and stops or steps to the next waveform.
module nco_seq_ctrl #(
    parameter int ACC_W     = 32,
    parameter int ADDR_W    = 5,
    parameter int DWELL_W   = 16,
    parameter int NUM_WAVES = 6
) (
    input logic           clk_50MHz,
    input logic           rst_n,
    nco_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam logic [3:0] WAVE_MAX = 4'(NUM_WAVES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_wave;
    logic [3:0]         r_sig;
    logic [ACC_W-1:0]   r_tw;
    logic [ACC_W-1:0]   r_acc;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_auto;
    logic               r_se;
    logic               r_err;
    logic [ACC_W:0]     w_acc_sum;
    logic [DWELL_W-1:0] w_cnt_inc;
    logic [3:0]         w_next_code;
    logic               w_carry;
    logic               w_end;
    logic               w_valid;
    logic               w_accept;

    assign w_acc_sum   = {1'b0, r_acc} + {1'b0, r_tw};
    assign w_carry     = w_acc_sum[ACC_W];
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_end       = w_carry && (r_dwell != '0) && (w_cnt_inc == r_dwell);
    assign w_next_code = (r_wave == WAVE_MAX) ? 4'd1 : r_wave + 4'd1;
    assign w_valid     = (bus.wave_sel != 4'd0) && (bus.wave_sel <= WAVE_MAX) && (bus.tuning_word != '0);
    assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.stop && w_valid;

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_nxt = S_ARM;
            S_ARM:   w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = w_end ? (r_auto ? S_LOAD : S_DONE) : S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.stop) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wave  <= '0;
            r_sig   <= '0;
            r_tw    <= '0;
            r_acc   <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_auto  <= 1'b0;
            r_se    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= (r_state == S_IDLE) && bus.start && !bus.stop && !w_valid;
            // registered strobe, high together with each new lut_addr value
            r_se    <= !bus.stop && (r_state == S_RUN) &&
                       (w_acc_sum[ACC_W-1 -: ADDR_W] != r_acc[ACC_W-1 -: ADDR_W]);
            if (bus.stop) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_wave  <= bus.wave_sel;
                r_tw    <= bus.tuning_word;
                r_dwell <= bus.dwell_cycles;
                r_auto  <= bus.auto_cycle;
            end else if (r_state == S_LOAD) begin
                r_sig <= r_wave;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_sum[ACC_W-1:0];
                if (w_carry) r_cnt <= w_cnt_inc;
                if (w_end && r_auto) r_wave <= w_next_code;
            end
        end
    end

    assign bus.signal_out = r_sig;
    assign bus.state_out  = r_state;
    assign bus.lut_addr   = r_acc[ACC_W-1 -: ADDR_W];
    assign bus.sample_en  = r_se;
    assign bus.busy       = (r_state == S_LOAD) || (r_state == S_ARM) || (r_state == S_RUN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = r_err;
endmodule

// File: tb/tb_nco_seq_ctrl.sv
// tb_nco_seq_ctrl: directed bench for nco_seq_ctrl; inputs driven and outputs
// sampled on the falling clock edge.
module tb_nco_seq_ctrl;
    localparam logic [31:0] TW27 = 32'h0800_0000;
    localparam logic [31:0] TW26 = 32'h0400_0000;

    logic clk_50MHz = 1'b0;
    logic rst_n     = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    nco_seq_ctrl_if bus ();

    nco_seq_ctrl dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_50MHz);
    endtask

    task automatic go(input logic [3:0] ws, input logic [31:0] tw, input logic [15:0] dw, input logic au);
        bus.wave_sel     = ws;
        bus.tuning_word  = tw;
        bus.dwell_cycles = dw;
        bus.auto_cycle   = au;
        bus.start        = 1'b1;
        step();
        bus.start        = 1'b0;
    endtask

    logic [3:0]  bad_ws  [3] = '{4'd0, 4'd7, 4'd3};
    logic [31:0] bad_tw  [3] = '{TW27, TW27, 32'd0};

    initial begin
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.wave_sel     = '0;
        bus.tuning_word  = '0;
        bus.dwell_cycles = '0;
        bus.auto_cycle   = 1'b0;
        step();
        step();
        chk("rst_state", 32'(bus.state_out), 0);
        chk("rst_sig", 32'(bus.signal_out), 0);
        chk("rst_addr", 32'(bus.lut_addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        rst_n = 1'b1;
        step();
        chk("rel_state", 32'(bus.state_out), 0);

        // single run, two periods of 32 samples, then done
        go(4'd1, TW27, 16'd2, 1'b0);
        bus.wave_sel = 4'd5;
        chk("t2_load", 32'(bus.state_out), 1);
        chk("t2_load_busy", 32'(bus.busy), 1);
        step();
        chk("t2_arm", 32'(bus.state_out), 2);
        chk("t2_arm_sig", 32'(bus.signal_out), 1);
        for (int k = 0; k < 64; k++) begin
            step();
            chk("t2_run_state", 32'(bus.state_out), 5);
            chk("t2_run_addr", 32'(bus.lut_addr), 32'(k % 32));
            chk("t2_run_se", 32'(bus.sample_en), (k == 0) ? 0 : 1);
            chk("t2_run_done", 32'(bus.done), 0);
        end
        step();
        chk("t2_done_state", 32'(bus.state_out), 6);
        chk("t2_done_pulse", 32'(bus.done), 1);
        chk("t2_done_busy", 32'(bus.busy), 0);
        chk("t2_done_sig", 32'(bus.signal_out), 1);
        step();
        chk("t2_idle_state", 32'(bus.state_out), 0);
        chk("t2_idle_done", 32'(bus.done), 0);
        chk("t2_idle_sig", 32'(bus.signal_out), 1);

        // auto-cycle from the top code, wrapping to 1
        go(4'd6, TW27, 16'd1, 1'b1);
        chk("t3_load", 32'(bus.state_out), 1);
        step();
        chk("t3_arm", 32'(bus.state_out), 2);
        chk("t3_arm_sig", 32'(bus.signal_out), 6);
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 32; r++) begin
                step();
                chk("t3_run_state", 32'(bus.state_out), 5);
                chk("t3_run_busy", 32'(bus.busy), 1);
            end
            step();
            chk("t3_reload", 32'(bus.state_out), 1);
            chk("t3_reload_busy", 32'(bus.busy), 1);
            chk("t3_reload_sig", 32'(bus.signal_out), (p == 0) ? 6 : 1);
            step();
            chk("t3_rearm", 32'(bus.state_out), 2);
            chk("t3_rearm_sig", 32'(bus.signal_out), (p == 0) ? 1 : 2);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("t3_stop_state", 32'(bus.state_out), 0);
        chk("t3_stop_busy", 32'(bus.busy), 0);
        chk("t3_stop_sig", 32'(bus.signal_out), 2);

        // rejected starts
        for (int i = 0; i < 3; i++) begin
            bus.wave_sel    = bad_ws[i];
            bus.tuning_word = bad_tw[i];
            bus.start       = 1'b1;
            step();
            chk("t4_err", 32'(bus.err), 1);
            chk("t4_state", 32'(bus.state_out), 0);
            bus.start = 1'b0;
            step();
            chk("t4_err_clear", 32'(bus.err), 0);
            chk("t4_state_hold", 32'(bus.state_out), 0);
        end

        // abort at RUN cycle 10, then start together with stop
        go(4'd2, TW27, 16'd0, 1'b0);
        step();
        for (int k = 0; k < 10; k++) step();
        chk("t5_pre_addr", 32'(bus.lut_addr), 9);
        bus.stop = 1'b1;
        step();
        chk("t5_state", 32'(bus.state_out), 0);
        chk("t5_addr", 32'(bus.lut_addr), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_err", 32'(bus.err), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_sig", 32'(bus.signal_out), 2);
        bus.wave_sel    = 4'd3;
        bus.tuning_word = TW27;
        bus.start       = 1'b1;
        step();
        chk("t5_ss_state", 32'(bus.state_out), 0);
        chk("t5_ss_err", 32'(bus.err), 0);
        bus.wave_sel = 4'd0;
        step();
        chk("t5_ss_bad_err", 32'(bus.err), 0);
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        step();
        chk("t5_after_state", 32'(bus.state_out), 0);

        // endless run at half sample rate
        go(4'd3, TW26, 16'd0, 1'b0);
        step();
        for (int k = 1; k <= 1000; k++) begin
            step();
            chk("t6_state", 32'(bus.state_out), 5);
            chk("t6_addr", 32'(bus.lut_addr), 32'(((k - 1) / 2) % 32));
            chk("t6_se", 32'(bus.sample_en), (k >= 3 && (k % 2) == 1) ? 1 : 0);
            chk("t6_done", 32'(bus.done), 0);
        end

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("t1_state", 32'(bus.state_out), 0);
        chk("t1_sig", 32'(bus.signal_out), 0);
        chk("t1_addr", 32'(bus.lut_addr), 0);
        chk("t1_se", 32'(bus.sample_en), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_done", 32'(bus.done), 0);
        chk("t1_err", 32'(bus.err), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t1_rel_state", 32'(bus.state_out), 0);
        chk("t1_rel_err", 32'(bus.err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
